// File: rtl/pwm_capture.sv
// pwm_capture: measures high time, period and duty of each PWM cycle.
// Defining PWM_CAP_FILTER_EN adds a 3-sample glitch filter ahead of edge detect.
module pwm_capture #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pwm_in,
  input  logic             meas_ack,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [7:0]       duty_percent,
  output logic             overflow,
  output logic             overrun,
  output logic [7:0]       cap_count
);
  localparam int DW = CNT_W + 7;
  localparam int IW = $clog2(DW + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_LOW  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic pwm_q, pwm_qq, lvl, lvl_d, rise, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q  <= 1'b0;
      pwm_qq <= 1'b0;
    end else begin
      pwm_q  <= pwm_in;
      pwm_qq <= pwm_q;
    end
  end

`ifdef PWM_CAP_FILTER_EN
  logic pwm_q3, filt, filt_nx;

  // level follows only after three equal samples
  assign filt_nx = (pwm_q == pwm_qq && pwm_qq == pwm_q3) ? pwm_q : filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q3 <= 1'b0;
      filt   <= 1'b0;
    end else begin
      pwm_q3 <= pwm_qq;
      filt   <= filt_nx;
    end
  end

  assign lvl   = filt_nx;
  assign lvl_d = filt;
`else
  assign lvl   = pwm_q;
  assign lvl_d = pwm_qq;
`endif

  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt, hi_tmp;
  logic             counting, sat, close;

  assign counting = (state == S_HIGH) || (state == S_LOW);
  assign sat      = enable && counting && (cnt == CNT_MAX);
  assign close    = enable && (state == S_LOW) && (cnt != CNT_MAX) && rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hi_tmp <= '0;
    end else if (!enable) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: state <= S_ARM;
        S_ARM: begin
          if (rise) begin
            state <= S_HIGH;
            cnt   <= CNT_ONE;
          end
        end
        S_HIGH: begin
          if (cnt == CNT_MAX) begin
            state <= S_ARM;
            cnt   <= '0;
          end else if (fall) begin
            hi_tmp <= cnt;
            cnt    <= cnt + CNT_ONE;
            state  <= S_LOW;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_LOW: begin
          if (cnt == CNT_MAX) begin
            state <= S_ARM;
            cnt   <= '0;
          end else if (rise) begin
            state <= S_HIGH;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic             div_busy, ge, start, drop, done;
  logic [IW-1:0]    div_idx;
  logic [CNT_W-1:0] div_rem, div_dvs, div_high, rem_lo, rem_nx;
  logic [DW-1:0]    div_dq, dq_nx;

  // remainder msb set means the shifted value already exceeds any divisor
  assign rem_lo = {div_rem[CNT_W-2:0], div_dq[DW-1]};
  assign ge     = div_rem[CNT_W-1] | (rem_lo >= div_dvs);
  assign rem_nx = ge ? rem_lo - div_dvs : rem_lo;
  assign dq_nx  = {div_dq[DW-2:0], ge};
  assign start  = close & ~div_busy;
  assign drop   = close & div_busy;
  assign done   = div_busy & (div_idx == IW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_busy <= 1'b0;
      div_idx  <= '0;
      div_rem  <= '0;
      div_dq   <= '0;
      div_dvs  <= '0;
      div_high <= '0;
    end else if (!enable) begin
      div_busy <= 1'b0;
      div_idx  <= '0;
      div_rem  <= '0;
      div_dq   <= '0;
    end else if (start) begin
      div_busy <= 1'b1;
      div_idx  <= IW'(DW);
      div_rem  <= '0;
      div_dq   <= DW'(hi_tmp) * DW'(100);
      div_dvs  <= cnt;
      div_high <= hi_tmp;
    end else if (div_busy) begin
      div_rem <= rem_nx;
      div_dq  <= dq_nx;
      div_idx <= div_idx - IW'(1);
      if (done) div_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_valid   <= 1'b0;
      high_cnt     <= '0;
      period_cnt   <= '0;
      duty_percent <= '0;
      overflow     <= 1'b0;
      overrun      <= 1'b0;
      cap_count    <= '0;
    end else if (!enable) begin
      meas_valid <= 1'b0;
    end else begin
      if (done) begin
        high_cnt     <= div_high;
        period_cnt   <= div_dvs;
        duty_percent <= dq_nx[7:0];
        meas_valid   <= 1'b1;
        cap_count    <= cap_count + 8'd1;
      end else if (meas_ack) begin
        meas_valid <= 1'b0;
      end
      if (sat) overflow <= 1'b1;
      else if (meas_ack) overflow <= 1'b0;
      if (drop || (done && meas_valid && !meas_ack)) overrun <= 1'b1;
      else if (meas_ack) overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: table + random PWM waveforms against a period/duty model.
// Hand sequences cover saturation, overwrite, enable drop and reset.
module tb_pwm_capture;
`ifdef PWM_CAP_FILTER_EN
  localparam int LAT  = 19;
  localparam int MINP = 3;
  localparam int SH   = 3;
  localparam int SL   = 3;
`else
  localparam int LAT  = 17;
  localparam int MINP = 1;
  localparam int SH   = 2;
  localparam int SL   = 3;
`endif
  localparam int BUSY = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       pwm_in = 1'b0;
  logic       meas_ack = 1'b0;
  logic       meas_valid, overflow, overrun;
  logic [7:0] high_cnt, period_cnt, duty_percent, cap_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_close = 0;
  int ack_reqs = 0;
  bit mon_on = 1'b0;

  typedef struct {
    int h; int p; int d; int ovf; int ovr; int lat; int clr;
  } res_t;
  typedef struct {
    int h; int l; int n; int eh; int ep; int ed;
  } vec_t;

  res_t res[$];
  vec_t tbl[10];

  pwm_capture #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pwm_in(pwm_in),
    .meas_ack(meas_ack), .meas_valid(meas_valid),
    .high_cnt(high_cnt), .period_cnt(period_cnt),
    .duty_percent(duty_percent), .overflow(overflow),
    .overrun(overrun), .cap_count(cap_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // closes occur every p cycles; the divider accepts one only BUSY cycles
  // after the last accepted close
  function automatic int n_accepted(input int p, input int n);
    int last, acc;
    last = -1000;
    acc = 0;
    for (int k = 1; k <= n; k++) begin
      if (k * p - last >= BUSY) begin
        acc++;
        last = k * p;
      end
    end
    return acc;
  endfunction

  // records every result it acknowledges; also serves manual ack requests
  initial begin : monitor
    int ack_done = 0;
    res_t r;
    forever begin
      @(negedge clk);
      if (mon_on && meas_valid) begin
        r.h = high_cnt;
        r.p = period_cnt;
        r.d = duty_percent;
        r.ovf = overflow;
        r.ovr = overrun;
        r.lat = cyc - t_close;
        meas_ack = 1'b1;
        @(negedge clk);
        meas_ack = 1'b0;
        r.clr = !meas_valid;
        res.push_back(r);
      end else if (ack_done < ack_reqs) begin
        ack_done++;
        meas_ack = 1'b1;
        @(negedge clk);
        meas_ack = 1'b0;
      end
    end
  end

  task automatic do_reset();
    enable = 1'b0;
    pwm_in = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    enable = 1'b1;
    tick();
  endtask

  // n full cycles, then a final rise that closes the last one
  task automatic gen_wave(input int h, input int l, input int n);
    pwm_in = 1'b0;
    repeat (4) tick();
    for (int k = 0; k <= n; k++) begin
      pwm_in = 1'b1;
      if (k == 1) t_close = cyc;
      if (k == n) break;
      repeat (h) tick();
      pwm_in = 1'b0;
      repeat (l) tick();
    end
  endtask

  task automatic run_vec(input int h, input int l, input int n,
                         input int eh, input int ep, input int ed);
    int base, acc;
    do_reset();
    base = res.size();
    acc = n_accepted(h + l, n);
    mon_on = 1'b1;
    gen_wave(h, l, n);
    repeat (40) tick();
    mon_on = 1'b0;
    chk("result_count", res.size() - base, acc);
    chk("cap_count", cap_count, acc);
    chk("overflow_end", overflow, 0);
    if (res.size() > base) begin
      chk("latency", res[base].lat, LAT);
      chk("first_overrun", res[base].ovr, (n >= 2 && h + l < BUSY) ? 1 : 0);
    end
    for (int i = base; i < res.size(); i++) begin
      chk("high_cnt", res[i].h, eh);
      chk("period_cnt", res[i].p, ep);
      chk("duty_percent", res[i].d, ed);
      chk("overflow", res[i].ovf, 0);
      chk("valid_cleared", res[i].clr, 1);
    end
  endtask

  initial begin
    int h, l, n, acc;
    tbl[0] = '{3, 7, 4, 3, 10, 30};
    tbl[1] = '{50, 50, 2, 50, 100, 50};
    tbl[2] = '{1, 1, 10, 1, 2, 50};
    tbl[3] = '{1, 20, 3, 1, 21, 4};
    tbl[4] = '{20, 1, 3, 20, 21, 95};
    tbl[5] = '{2, 98, 2, 2, 100, 2};
    tbl[6] = '{100, 154, 2, 100, 254, 39};
    tbl[7] = '{200, 54, 1, 200, 254, 78};
    tbl[8] = '{8, 8, 3, 8, 16, 50};
    tbl[9] = '{7, 8, 3, 7, 15, 46};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", meas_valid, 0);
    chk("rst_high", high_cnt, 0);
    chk("rst_period", period_cnt, 0);
    chk("rst_duty", duty_percent, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cap", cap_count, 0);

    for (int i = 0; i < 10; i++)
      if (tbl[i].h >= MINP && tbl[i].l >= MINP)
        run_vec(tbl[i].h, tbl[i].l, tbl[i].n,
                tbl[i].eh, tbl[i].ep, tbl[i].ed);

    for (int i = 0; i < 12; i++) begin
      h = $urandom_range(60, MINP);
      l = $urandom_range(60, MINP);
      n = $urandom_range(4, 1);
      run_vec(h, l, n, h, h + l, (h * 100) / (h + l));
    end

    // constant high after a single rise saturates and never reports
    do_reset();
    gen_wave(5, 5, 0);
    acc = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (meas_valid) acc++;
      if (i == 200) chk("ovf_not_yet", overflow, 0);
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_no_valid", acc, 0);
    chk("ovf_cap", cap_count, 0);
    ack_reqs++;
    repeat (3) tick();
    chk("ovf_ack_clear", overflow, 0);

    // unacked 20-cycle period: later results overwrite
    do_reset();
    gen_wave(10, 10, 3);
    repeat (40) tick();
    chk("ow_valid", meas_valid, 1);
    chk("ow_overrun", overrun, 1);
    chk("ow_cap", cap_count, 3);
    chk("ow_high", high_cnt, 10);
    chk("ow_period", period_cnt, 20);
    chk("ow_duty", duty_percent, 50);

    // short period: closes during a divide are dropped
    do_reset();
    gen_wave(SH, SL, 8);
    repeat (40) tick();
    chk("short_cap", cap_count, n_accepted(SH + SL, 8));
    chk("short_overrun", overrun, 1);
    chk("short_high", high_cnt, SH);
    chk("short_duty", duty_percent, (SH * 100) / (SH + SL));

    rst_n = 1'b0;
    #2;
    chk("midrst_valid", meas_valid, 0);
    chk("midrst_cap", cap_count, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_high", high_cnt, 0);

    // enable dropped mid-HIGH keeps results but clears valid
    do_reset();
    gen_wave(4, 6, 1);
    repeat (20) tick();
    chk("en_valid_before", meas_valid, 1);
    enable = 1'b0;
    repeat (3) tick();
    chk("en_valid_off", meas_valid, 0);
    chk("en_high_held", high_cnt, 4);
    chk("en_period_held", period_cnt, 10);
    chk("en_cap_held", cap_count, 1);
    enable = 1'b1;
    gen_wave(6, 4, 1);
    repeat (20) tick();
    chk("en_new_valid", meas_valid, 1);
    chk("en_new_high", high_cnt, 6);
    chk("en_new_duty", duty_percent, 60);
    chk("en_new_cap", cap_count, 2);

`ifdef PWM_CAP_FILTER_EN
    do_reset();
    repeat (4) tick();
    pwm_in = 1'b1; repeat (3) tick();
    pwm_in = 1'b0; tick();
    pwm_in = 1'b1; repeat (2) tick();
    pwm_in = 1'b0; repeat (4) tick();
    pwm_in = 1'b1;
    repeat (25) tick();
    chk("glitch_high", high_cnt, 6);
    chk("glitch_period", period_cnt, 10);
    chk("glitch_duty", duty_percent, 60);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
